// File: rtl/mem_buf.sv
// mem_buf: in-order load/store buffer between the ALU lanes and the data bus.
// Memory ops are queued in a small FIFO and issued one at a time over a
// request/grant bus. Returned load data is formatted and written back through
// mem_sel/mem_data. pend_rd flags destinations with an outstanding load.
module mem_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  // upstream op interface
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_we,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  // data-memory bus
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  // register-file write port and hazard info
  output logic [4:0]      mem_sel,
  output logic [XLEN-1:0] mem_data,
  output logic [31:0]     pend_rd,
  output logic            empty
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]  ONE_CNT  = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [4:0]       mem_sel_q, mem_sel_d;
  logic [XLEN-1:0]  mem_data_q, mem_data_d;

  entry_t           head;
  entry_t           in_entry;
  logic             push, pop;
  logic             more_left;
  logic [XLEN-1:0]  load_data;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [PTR_W-1:0] off;

  assign head      = fifo_q[rd_ptr_q];
  assign in_ready  = (count_q != FULL_CNT);
  assign push      = in_valid & in_ready;
  // Entries remaining after the head pops (a same-cycle push counts).
  assign more_left = (count_q != ONE_CNT) | push;
  assign empty     = (count_q == '0) && (state_q == S_IDLE);

  assign in_entry = '{we: in_we, funct3: in_funct3, addr: in_addr,
                      wdata: in_wdata, rd: in_rd};

  // Bus request fields are derived from the head entry and hold until grant.
  assign dmem_req  = (state_q == S_REQ);
  assign dmem_we   = dmem_req & head.we;
  assign dmem_addr = {head.addr[XLEN-1:2], 2'b00};

  assign mem_sel  = mem_sel_q;
  assign mem_data = mem_data_q;

  // Store formatting: byte enables and lane-replicated write data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dmem_be    = 4'b1111;
    dmem_wdata = head.wdata;
    case (head.funct3)
      3'b000: begin
        dmem_be    = 4'b0001 << head.addr[1:0];
        dmem_wdata = {4{head.wdata[7:0]}};
      end
      3'b001: begin
        dmem_be    = 4'b0011 << {head.addr[1], 1'b0};
        dmem_wdata = {2{head.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting: lane select plus sign/zero extension.
  always_comb begin
    case (head.addr[1:0])
      2'd0:    byte_v = dmem_rdata[7:0];
      2'd1:    byte_v = dmem_rdata[15:8];
      2'd2:    byte_v = dmem_rdata[23:16];
      default: byte_v = dmem_rdata[31:24];
    endcase
    half_v = head.addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (head.funct3)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_data = {24'h0, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b101:  load_data = {16'h0, half_v};
      default: load_data = dmem_rdata;
    endcase
  end

  // Issue FSM: next state, head pop and write-back generation.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    mem_sel_d  = '0;
    mem_data_d = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_REQ;
      end
      S_REQ: begin
        if (dmem_gnt) begin
          if (head.we) begin
            pop     = 1'b1;
            state_d = more_left ? S_REQ : S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          pop        = 1'b1;
          mem_sel_d  = head.rd;
          mem_data_d = load_data;
          state_d    = more_left ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy count follows push/pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state, pointers and write-back registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_sel_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mem_sel_q  <= mem_sel_d;
      mem_data_q <= mem_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count/pointers alone decide which slots are valid.
    if (push) fifo_q[wr_ptr_q] <= in_entry;
  end

  // Pending-destination bitmap over all valid load entries, head included.
  always_comb begin
    pend_rd = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && !fifo_q[i].we && (fifo_q[i].rd != 5'd0)) begin
        pend_rd[fifo_q[i].rd] = 1'b1;
      end
    end
    pend_rd[0] = 1'b0;
  end

endmodule
